// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID/redirect/memory-handshake inputs and pipeline enable/clear outputs of the hazard unit.
// HAZARD_PERF_EN adds the event counter outputs.
interface hazard_scoreboard_if #(parameter int RW = 5);
   logic          id_valid;
   logic [RW-1:0] id_rs, id_rt, id_wr_reg;
   logic          id_uses_rs, id_uses_rt, id_is_load, id_jump;
   logic          redirect, mem_req, mem_ready;
   logic          if_en, id_en, ex_en, mem_en, wb_en;
   logic          id_clr, ex_clr, mem_clr, mem_err;
`ifdef HAZARD_PERF_EN
   logic [31:0]   stall_cnt, flush_cnt, freeze_cnt;
`endif
   modport master (
      output id_valid, id_rs, id_rt, id_wr_reg, id_uses_rs, id_uses_rt, id_is_load, id_jump,
      output redirect, mem_req, mem_ready,
`ifdef HAZARD_PERF_EN
      input  stall_cnt, flush_cnt, freeze_cnt,
`endif
      input  if_en, id_en, ex_en, mem_en, wb_en, id_clr, ex_clr, mem_clr, mem_err
   );
   modport slave (
      input  id_valid, id_rs, id_rt, id_wr_reg, id_uses_rs, id_uses_rt, id_is_load, id_jump,
      input  redirect, mem_req, mem_ready,
`ifdef HAZARD_PERF_EN
      output stall_cnt, flush_cnt, freeze_cnt,
`endif
      output if_en, id_en, ex_en, mem_en, wb_en, id_clr, ex_clr, mem_clr, mem_err
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-pending scoreboard hazard unit with memory-ready freeze and precise branch flush.
// Define HAZARD_PERF_EN to add saturating stall/flush/freeze event counters.
module hazard_scoreboard #(
   parameter int RW          = 5,
   parameter int LOAD_LAT    = 1,
   parameter int BR_STAGE    = 2,
   parameter int MEM_TIMEOUT = 255
) (
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave hz
);
   typedef enum logic {IDLE, WAIT} state_t;
   localparam logic KILL_EX = BR_STAGE == 2;
   state_t                      state;
   logic [7:0]                  wcnt;
   logic                        err;
   logic [LOAD_LAT-1:0]         lp_v;
   logic [LOAD_LAT-1:0][RW-1:0] lp_r;
   logic                        freeze, ldstall, hit_rs, hit_rt, rec, bubble, front, kill;
   always_comb begin
      hit_rs = 1'b0;
      hit_rt = 1'b0;
      for (int k = 0; k < LOAD_LAT; k++) begin
         hit_rs = hit_rs | (lp_v[k] & (lp_r[k] == hz.id_rs));
         hit_rt = hit_rt | (lp_v[k] & (lp_r[k] == hz.id_rt));
      end
   end
   assign freeze     = hz.mem_req & ~hz.mem_ready;
   assign ldstall    = hz.id_valid & ((hz.id_uses_rs & |hz.id_rs & hit_rs) | (hz.id_uses_rt & |hz.id_rt & hit_rt));
   assign rec        = hz.id_valid & hz.id_is_load & |hz.id_wr_reg & ~ldstall & ~hz.redirect;
   assign kill       = KILL_EX & hz.redirect;
   // redirect outranks the load stall: the stalled consumer is being flushed anyway
   assign front      = ~freeze & (hz.redirect | ~ldstall);
   assign bubble     = ~freeze & (hz.redirect | (~ldstall & hz.id_jump));
   assign hz.if_en   = front;
   assign hz.id_en   = front;
   assign hz.ex_en   = ~freeze;
   assign hz.mem_en  = ~freeze;
   assign hz.wb_en   = ~freeze;
   assign hz.id_clr  = bubble;
   assign hz.ex_clr  = ~freeze & (hz.redirect | ldstall);
   assign hz.mem_clr = ~freeze & kill;
   assign hz.mem_err = err;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         lp_v <= '0;
         lp_r <= '0;
      end else if (!freeze) begin
         lp_v[0] <= rec;
         lp_r[0] <= rec ? hz.id_wr_reg : '0;
         for (int k = 1; k < LOAD_LAT; k++) begin
            lp_v[k] <= lp_v[k-1] & ~((k == 1) & kill);
            lp_r[k] <= ((k == 1) & kill) ? '0 : lp_r[k-1];
         end
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         wcnt  <= '0;
         err   <= 1'b0;
      end else if (state == IDLE) begin
         wcnt  <= '0;
         state <= freeze ? WAIT : IDLE;
      end else begin
         wcnt  <= wcnt + 8'(~&wcnt);
         err   <= err | (9'(wcnt) + 9'd1 >= 9'(MEM_TIMEOUT));
         state <= hz.mem_ready ? IDLE : WAIT;
      end
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         freeze_cnt <= '0;
      end else begin
         stall_cnt  <= stall_cnt + 32'(~freeze & ~hz.redirect & ldstall & ~&stall_cnt);
         flush_cnt  <= flush_cnt + 32'(bubble & ~&flush_cnt);
         freeze_cnt <= freeze_cnt + 32'(freeze & ~&freeze_cnt);
      end
   assign hz.stall_cnt  = stall_cnt;
   assign hz.flush_cnt  = flush_cnt;
   assign hz.freeze_cnt = freeze_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: two configurations driven by shared stimulus, checked against an issue-time load model.
module tb_hazard_scoreboard;
   localparam int LLA [2] = '{1, 3};
   localparam int BSA [2] = '{1, 2};
   localparam int TOA [2] = '{3, 6};
   localparam logic [8:0] N = 9'b11111_000_0;
   localparam logic [8:0] S = 9'b00111_010_0;
   localparam logic [8:0] J = 9'b11111_100_0;
   logic       clk = 1'b0, reset = 1'b1;
   logic       id_valid, id_uses_rs, id_uses_rt, id_is_load, id_jump, redirect, mem_req, mem_ready;
   logic [4:0] id_rs, id_rt, id_wr_reg;
   logic [8:0] outs [2];
   int         vecs = 0, errs = 0;
   int         adv [2], wc [2];
   bit         waiting [2], err [2];
   bit         ev [2][16];
   logic [4:0] er [2][16];
   int         et [2][16];
   always #5 clk = ~clk;
   hazard_scoreboard_if #(.RW(5)) h [2] ();
   for (genvar g = 0; g < 2; g++) begin : u
      assign h[g].id_valid   = id_valid;
      assign h[g].id_rs      = id_rs;
      assign h[g].id_rt      = id_rt;
      assign h[g].id_wr_reg  = id_wr_reg;
      assign h[g].id_uses_rs = id_uses_rs;
      assign h[g].id_uses_rt = id_uses_rt;
      assign h[g].id_is_load = id_is_load;
      assign h[g].id_jump    = id_jump;
      assign h[g].redirect   = redirect;
      assign h[g].mem_req    = mem_req;
      assign h[g].mem_ready  = mem_ready;
      assign outs[g] = {h[g].if_en, h[g].id_en, h[g].ex_en, h[g].mem_en, h[g].wb_en,
                        h[g].id_clr, h[g].ex_clr, h[g].mem_clr, h[g].mem_err};
      hazard_scoreboard #(.RW(5), .LOAD_LAT(LLA[g]), .BR_STAGE(BSA[g]), .MEM_TIMEOUT(TOA[g])) dut (
         .clk(clk), .reset(reset), .hz(h[g]));
   end
   // A load issued at advance count t blocks its register while the count lies in t+1 .. t+LOAD_LAT.
   function automatic bit hit(int i, logic [4:0] r);
      bit f = 0;
      for (int j = 0; j < 16; j++)
         if (ev[i][j] && er[i][j] == r && adv[i] <= et[i][j] + LLA[i]) f = 1;
      return f;
   endfunction
   function automatic bit stall_now(int i);
      return id_valid && ((id_uses_rs && id_rs != 0 && hit(i, id_rs)) || (id_uses_rt && id_rt != 0 && hit(i, id_rt)));
   endfunction
   function automatic logic [8:0] expect_out(int i);
      if (mem_req && !mem_ready) return {8'h00, err[i]};
      if (redirect) return {5'h1F, 2'b11, BSA[i] == 2, err[i]};
      if (stall_now(i)) return S | {8'h00, err[i]};
      return {5'h1F, id_jump, 2'b00, err[i]};
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         adv[i] = 0; wc[i] = 0; waiting[i] = 0; err[i] = 0;
         for (int j = 0; j < 16; j++) ev[i][j] = 0;
      end
   endtask
   task automatic model_step(int i);
      bit fr, ls;
      fr = mem_req && !mem_ready;
      ls = stall_now(i);
      if (!waiting[i]) begin
         if (fr) begin waiting[i] = 1; wc[i] = 0; end
      end else begin
         if (wc[i] < 255) wc[i]++;
         if (wc[i] >= TOA[i]) err[i] = 1;
         if (mem_ready) waiting[i] = 0;
      end
      if (!fr) begin
         for (int j = 0; j < 16; j++)
            if (redirect && BSA[i] == 2 && et[i][j] == adv[i] - 1) ev[i][j] = 0;
         if (id_valid && id_is_load && id_wr_reg != 0 && !ls && !redirect)
            for (int j = 0; j < 16; j++)
               if (!ev[i][j]) begin ev[i][j] = 1; er[i][j] = id_wr_reg; et[i][j] = adv[i]; break; end
         adv[i]++;
         for (int j = 0; j < 16; j++)
            if (ev[i][j] && adv[i] > et[i][j] + LLA[i]) ev[i][j] = 0;
      end
   endtask
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (reset) model_reset();
         for (int i = 0; i < 2; i++) begin
            e = expect_out(i);
            vecs++;
            if (outs[i] !== e) begin
               errs++;
               $display("FAIL model u%0d @%0t: got %b want %b", i, $time, outs[i], e);
            end
            if (!reset) model_step(i);
         end
      end
   end
   task automatic chk(string nm, int i, logic [8:0] want);
      vecs++;
      if (outs[i] !== want) begin
         errs++;
         $display("FAIL %s u%0d: got %b want %b", nm, i, outs[i], want);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic put(bit v, bit ld, logic [4:0] wr, bit urs, logic [4:0] rs);
      id_valid = v; id_is_load = ld; id_wr_reg = wr; id_uses_rs = urs; id_rs = rs;
      id_uses_rt = 0; id_rt = 0;
   endtask
   task automatic idle(int n);
      repeat (n) begin cyc(); put(0, 0, 0, 0, 0); id_jump = 0; redirect = 0; mem_req = 0; mem_ready = 0; end
   endtask
   initial begin
      put(0, 0, 0, 0, 0);
      id_jump = 0; redirect = 0; mem_req = 0; mem_ready = 0;
      #2 chk("reset", 0, N); chk("reset", 1, N);
      repeat (2) cyc();
      reset = 0;
      idle(2);
      // load-use: 1 stall for LOAD_LAT=1, 3 stalls for LOAD_LAT=3
      cyc(); put(1, 1, 2, 0, 0);  #1 chk("lw2", 0, N); chk("lw2", 1, N);
      cyc(); put(1, 0, 3, 1, 2);  #1 chk("use_c1", 0, S); chk("use_c1", 1, S);
      cyc(); #1 chk("use_c2", 0, N); chk("use_c2", 1, S);
      cyc(); #1 chk("use_c3", 1, S);
      cyc(); #1 chk("use_c4", 1, N);
      idle(4);
      cyc(); put(1, 1, 0, 0, 0);
      cyc(); put(1, 0, 3, 1, 0);  #1 chk("r0", 0, N); chk("r0", 1, N);
      cyc(); put(1, 1, 5, 0, 0);
      cyc(); put(1, 0, 3, 1, 6);  #1 chk("r6", 0, N); chk("r6", 1, N);
      cyc(); put(1, 0, 3, 1, 5);  #1 chk("r5_late", 0, N); chk("r5_late", 1, S);
      idle(4);
      // freeze holds the scoreboard; mem_err after 3 wait cycles with timeout 3
      cyc(); put(1, 1, 7, 0, 0);
      cyc(); put(1, 0, 3, 1, 7); mem_req = 1; mem_ready = 0; #1 chk("frz1", 0, 9'h000); chk("frz1", 1, 9'h000);
      repeat (3) begin cyc(); #1 chk("frz", 0, 9'h000); chk("frz", 1, 9'h000); end
      cyc(); mem_ready = 1; #1 chk("rel", 0, S | 9'h001); chk("rel", 1, S);
      cyc(); mem_req = 0; mem_ready = 0; #1 chk("post", 0, N | 9'h001); chk("post", 1, S);
      idle(4);
      // redirect kills the load in EX only when resolving in MEM
      cyc(); put(1, 1, 3, 0, 0);
      cyc(); put(1, 0, 4, 1, 3); redirect = 1;
      #1 chk("redir", 0, 9'b11111_110_1); chk("redir", 1, 9'b11111_111_0);
      cyc(); redirect = 0; #1 chk("redir_n1", 0, N | 9'h001); chk("redir_n1", 1, N);
      cyc(); #1 chk("redir_n2", 1, N);
      idle(2);
      cyc(); redirect = 1; mem_req = 1; #1 chk("rfrz", 0, 9'h001); chk("rfrz", 1, 9'h000);
      cyc(); #1 chk("rfrz2", 0, 9'h001); chk("rfrz2", 1, 9'h000);
      cyc(); mem_ready = 1; #1 chk("rrel", 0, 9'b11111_110_1); chk("rrel", 1, 9'b11111_111_0);
      cyc(); redirect = 0; mem_req = 0; mem_ready = 0; put(1, 0, 4, 0, 0); id_jump = 1;
      #1 chk("jump", 0, J | 9'h001); chk("jump", 1, J);
      cyc(); id_jump = 0; #1 chk("jump_end", 0, N | 9'h001); chk("jump_end", 1, N);
      // ldstall beats jump
      cyc(); put(1, 1, 9, 0, 0);
      cyc(); put(1, 0, 4, 1, 9); id_jump = 1; #1 chk("ls_j", 0, S | 9'h001); chk("ls_j", 1, S);
      cyc(); #1 chk("ls_j2", 0, J | 9'h001); chk("ls_j2", 1, S);
      idle(4);
      // asynchronous reset in the middle of a wait
      cyc(); put(1, 1, 10, 0, 0);
      cyc(); put(1, 0, 4, 1, 10); mem_req = 1; mem_ready = 0; #1 chk("pre_rst", 0, 9'h001);
      cyc();
      @(posedge clk); #3 reset = 1;
      #1 chk("arst_err", 0, 9'h000);
      mem_req = 0;
      #1 chk("arst_sb", 0, N); chk("arst_sb", 1, N);
      cyc(); reset = 0;
      idle(2);
      for (int n = 0; n < 3000; n++) begin
         cyc();
         reset      = (n % 500) == 250;
         id_valid   = $urandom_range(0, 9) != 0;
         id_rs      = 5'($urandom_range(0, 7));
         id_rt      = 5'($urandom_range(0, 7));
         id_wr_reg  = 5'($urandom_range(0, 7));
         id_uses_rs = $urandom_range(0, 3) != 0;
         id_uses_rt = $urandom_range(0, 1) != 0;
         id_is_load = $urandom_range(0, 2) == 0;
         id_jump    = $urandom_range(0, 9) == 0;
         redirect   = $urandom_range(0, 9) == 0;
         mem_req    = $urandom_range(0, 3) == 0;
         mem_ready  = $urandom_range(0, 1) != 0;
      end
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised second-generation hazard unit for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Replaces the single-cycle load-use compare with a load-pending scoreboard whose depth is set by load latency.
- Adds a data-memory ready handshake that freezes the whole pipeline, plus configurable branch-resolve stage with precise younger-instruction flush.
- Sits beside the Forwarding unit and drives all pipeline-register enables and clears.

Parameters:
- RW, 5, register-address width.
- LOAD_LAT, 1, cycles a load result is unforwardable after the load enters EX (1..4); sets scoreboard depth.
- BR_STAGE, 2, stage where branch/jr redirect resolves (1 = EX, 2 = MEM).
- MEM_TIMEOUT, 255, maximum consecutive wait cycles before mem_err is set (8-bit counter).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RW  ID source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_is_load  in  1  ID instruction is a load
- id_wr_reg  in  RW  ID destination register (after regdst/jal select)
- id_jump  in  1  j/jal in ID
- redirect  in  1  branch taken or jr in stage BR_STAGE
- mem_req  in  1  MEM stage holds a load/store
- mem_ready  in  1  data memory completes this cycle
- if_en, id_en  out  1  PC and IF/ID register enables
- ex_en, mem_en, wb_en  out  1  later pipeline register enables
- id_clr, ex_clr, mem_clr  out  1  synchronous clear (bubble) of IF/ID, ID/EX, EX/MEM registers
- mem_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset:
  - Scoreboard entries lp[0..LOAD_LAT-1] = 0; FSM = IDLE; wait counter = 0; mem_err = 0.
  - All clr outputs = 0; all en outputs = 1 (these are combinational from cleared state).
- freeze = mem_req & ~mem_ready.
  - While freeze: all en = 0, all clr = 0, scoreboard and hazard decisions held.
  - freeze has priority over every other event.
- Memory FSM:
  - IDLE -> WAIT on freeze.
  - WAIT -> IDLE on mem_ready.
  - The wait counter increments in WAIT and clears in IDLE.
  - When the counter reaches MEM_TIMEOUT, mem_err sets and stays set until reset. The pipeline keeps waiting.
- Scoreboard entry: {valid, reg}, where lp[k] is the load k stages past EX entry.
  - When the pipeline advances (~freeze): lp[k] <= lp[k-1] for k >= 1.
  - lp[0] <= {1, id_wr_reg} if id_valid & id_is_load & id_wr_reg != 0 & ~ldstall & ~redirect; otherwise lp[0] <= 0.
- ldstall = id_valid & ((id_uses_rs & id_rs != 0 & hit(id_rs)) | (id_uses_rt & id_rt != 0 & hit(id_rt))).
  - hit(r) = any valid lp[k] with reg == r.
  - On ldstall & ~freeze & ~redirect: if_en = id_en = 0; ex_clr = 1 (bubble); later stages advance.
  - A consumer stalls for exactly LOAD_LAT cycles after its producer load in the adjacent slot.
- redirect & ~freeze:
  - id_clr = 1 and ex_clr = 1.
  - mem_clr = 1 only if BR_STAGE == 2.
  - Scoreboard entries belonging to killed instructions are zeroed: lp[0] new = 0, and if BR_STAGE == 2, lp[1] new = 0.
  - redirect overrides ldstall and id_jump; if_en = 1 (PC takes target).
- id_jump & ~freeze & ~redirect & ~ldstall: id_clr = 1 for one cycle. This is a bubble, not a stall; PC loads the target.
- ldstall & id_jump together: ldstall wins; the jump re-evaluates next cycle.
- Register 0 is never recorded or matched.

Optional Feature:
- HAZARD_PERF_EN. When defined, adds outputs stall_cnt [31:0], flush_cnt [31:0], freeze_cnt [31:0].
  - Each counter is saturating at 32'hFFFFFFFF and cleared by reset.
  - stall_cnt increments on each ldstall cycle.
  - flush_cnt increments on each redirect or jump bubble.
  - freeze_cnt increments on each freeze cycle.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- LOAD_LAT=1: lw $2 enters EX, ID add reads $2 -> if_en = id_en = 0 and ex_clr = 1 for exactly 1 cycle, then add proceeds. The same with LOAD_LAT=3 -> 3 stall cycles.
- lw $0 followed by add using $0 -> no stall. A load to $5 followed by a consumer of $6 -> no stall.
- mem_req = 1, mem_ready = 0 for 4 cycles -> all en = 0 for 4 cycles, FSM in WAIT, scoreboard unchanged. Cycle 5 with mem_ready = 1 -> FSM to IDLE, pipeline advances.
- BR_STAGE=2: redirect while a load is in EX and its consumer is in ID -> id_clr = ex_clr = mem_clr = 1, the load's entry is dropped, no stall next cycle. With BR_STAGE=1 -> mem_clr = 0.
- redirect during freeze -> no clears until mem_ready; clears occur in the release cycle. id_jump alone -> id_clr = 1 for one cycle, if_en = 1.
- MEM_TIMEOUT = 3, mem_ready held low -> mem_err = 1 after 3 wait cycles and remains 1 after the release. Asserting reset mid-WAIT -> all state cleared immediately (asynchronous).
